addsub_rr_sched: RTL and testbench

- Round-robin scheduler that shares one offset-subtract datapath, RES = (A + B) - SEQ, among N requesters.
- SEQ is an internal issue counter that increments on every grant.
- Each requester uses a valid/ready handshake. A single result register with a requester tag drives one downstream valid/ready consumer.
- Sits between multiple producer pipelines and one shared arithmetic resource.

---
 rtl/addsub_rr_sched.sv | 135 +++++++++++++
 tb/tb_addsub_rr_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_sched.sv
// addsub_rr_sched: round-robin scheduler sharing one offset-subtract datapath
// RES = (A + B) - SEQ among N valid/ready requesters, with a single tagged
// result register feeding one downstream consumer.
//
// Optional feature macro: ADDSUB_RR_SCHED_STATS_EN
//   When defined, adds STALL_CNT (saturating backpressure-cycle counter) and
//   GRANT_CNT (wrapping grant counter) output ports.
module addsub_rr_sched #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEQ_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N-1:0]           REQ_VALID,
  output logic [N-1:0]           REQ_READY,
  input  logic [N*W-1:0]         REQ_A,
  input  logic [N*W-1:0]         REQ_B,
  output logic                   RES_VALID,
  input  logic                   RES_READY,
  output logic [W-1:0]           RES_DATA,
  output logic [$clog2(N)-1:0]   RES_ID,
`ifdef ADDSUB_RR_SCHED_STATS_EN
  output logic [15:0]            STALL_CNT,
  output logic [15:0]            GRANT_CNT,
`endif
  output logic [SEQ_W-1:0]       SEQ
);

  localparam int IDW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             slot_free;
  logic [SEQ_W-1:0] seq_inc;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic [W-1:0]     res_calc;

  assign RES_VALID = (state == FULL);
  assign slot_free = (state == IDLE) | (RES_VALID & RES_READY);
  assign seq_inc   = SEQ + 1'b1;

  // Circular priority scan starting at ptr; grant only when the slot frees up
  always_comb begin
    int             jj;
    logic [IDW-1:0] j;
    grant_any = 1'b0;
    grant_idx = '0;
    jj        = 0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      jj = int'(ptr) + k;
      if (jj >= N) jj = jj - N;
      j = IDW'(jj);
      if (!grant_any && slot_free && !RST && REQ_VALID[j]) begin
        grant_any = 1'b1;
        grant_idx = j;
      end
    end
  end

  // One-hot ready for the winner, operand mux and shared offset-subtract datapath
  always_comb begin
    REQ_READY = '0;
    if (grant_any) REQ_READY = N'(1) << grant_idx;
    a_sel    = REQ_A[int'(grant_idx)*W +: W];
    b_sel    = REQ_B[int'(grant_idx)*W +: W];
    res_calc = a_sel + b_sel - W'(seq_inc);
  end

  // Next state: a grant always fills the slot, a drain without grant empties it
  always_comb begin
    state_next = state;
    if (grant_any) begin
      state_next = FULL;
    end else if ((state == FULL) && RES_READY) begin
      state_next = IDLE;
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Result register, issue counter and round-robin pointer update on grant
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RES_DATA <= '0;
      RES_ID   <= '0;
      SEQ      <= '0;
      ptr      <= '0;
    end else if (grant_any) begin
      RES_DATA <= res_calc;
      RES_ID   <= grant_idx;
      SEQ      <= seq_inc;
      if (int'(grant_idx) == N - 1) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + 1'b1;
      end
    end
  end

`ifdef ADDSUB_RR_SCHED_STATS_EN
  // Backpressure cycles (saturating) and total grants (wrapping)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STALL_CNT <= '0;
      GRANT_CNT <= '0;
    end else begin
      if (RES_VALID && !RES_READY && (STALL_CNT != 16'hFFFF)) begin
        STALL_CNT <= STALL_CNT + 16'd1;
      end
      if (grant_any) begin
        GRANT_CNT <= GRANT_CNT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub_rr_sched.sv
// tb_addsub_rr_sched: randomized scoreboard bench for addsub_rr_sched with a
// behavioural arbitration/arithmetic model and a decoupled result monitor.
module tb_addsub_rr_sched;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SEQ_W = 8;
  localparam int IDW   = $clog2(N);

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [N-1:0]     REQ_VALID = '0;
  logic [N-1:0]     REQ_READY;
  logic [N*W-1:0]   REQ_A = '0;
  logic [N*W-1:0]   REQ_B = '0;
  logic             RES_VALID;
  logic             RES_READY = 1'b0;
  logic [W-1:0]     RES_DATA;
  logic [IDW-1:0]   RES_ID;
  logic [SEQ_W-1:0] SEQ;
`ifdef ADDSUB_RR_SCHED_STATS_EN
  logic [15:0]      STALL_CNT;
  logic [15:0]      GRANT_CNT;
`endif

  addsub_rr_sched #(.N(N), .W(W), .SEQ_W(SEQ_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_DATA  (RES_DATA),
    .RES_ID    (RES_ID),
`ifdef ADDSUB_RR_SCHED_STATS_EN
    .STALL_CNT (STALL_CNT),
    .GRANT_CNT (GRANT_CNT),
`endif
    .SEQ       (SEQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t sbq[$];
  int   nCmp  = 0;
  int   nFail = 0;

  // Reference model state, at the level of "what the scheduler has done so far"
  int   mPtr    = 0;
  int   mSeq    = 0;
  bit   mFull   = 1'b0;
  int   mGrants = 0;
  int   mStalls = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rndOps();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [N*W-1:0] opsAt(input int idx, input int val);
    logic [N*W-1:0] r;
    r = '0;
    r[idx*W +: W] = W'(val);
    return r;
  endfunction

  task automatic modelReset();
    mPtr    = 0;
    mSeq    = 0;
    mFull   = 1'b0;
    mGrants = 0;
    mStalls = 0;
    sbq.delete();
  endtask

  // Drive one cycle of inputs, check combinational/registered outputs, advance the model
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] a,
                               input logic [N*W-1:0] b, input logic rdy);
    int   g;
    int   ai;
    int   bi;
    int   d;
    bit   freeSlot;
    logic [N-1:0] expReady;
    @(posedge CLK);
    #1;
    REQ_VALID = v;
    REQ_A     = a;
    REQ_B     = b;
    RES_READY = rdy;
    #1;
    freeSlot = !mFull || rdy;
    g        = freeSlot ? pickWinner(v, mPtr) : -1;
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", 32'(REQ_READY), 32'(expReady));
    checkOutput("seq", 32'(SEQ), 32'(mSeq));
    checkOutput("res_valid", 32'(RES_VALID), 32'(mFull));
`ifdef ADDSUB_RR_SCHED_STATS_EN
    checkOutput("grant_cnt", 32'(GRANT_CNT), 32'(mGrants));
    checkOutput("stall_cnt", 32'(STALL_CNT), 32'(mStalls));
`endif
    if (mFull && !rdy && mStalls < 65535) mStalls++;
    if (g >= 0) begin
      mSeq = (mSeq + 1) % (1 << SEQ_W);
      ai   = int'(a[g*W +: W]);
      bi   = int'(b[g*W +: W]);
      d    = (ai + bi - mSeq) % (1 << W);
      if (d < 0) d += (1 << W);
      sbq.push_back('{id: g, data: d});
      mPtr    = (g + 1) % N;
      mGrants = (mGrants + 1) % 65536;
    end
    mFull = (g >= 0) || (mFull && !rdy);
  endtask

  task automatic doReset();
    REQ_VALID = '0;
    RES_READY = 1'b0;
    RST       = 1'b1;
    #1;
    checkOutput("rst_res_valid", 32'(RES_VALID), 32'd0);
    checkOutput("rst_res_data", 32'(RES_DATA), 32'd0);
    checkOutput("rst_res_id", 32'(RES_ID), 32'd0);
    checkOutput("rst_seq", 32'(SEQ), 32'd0);
    checkOutput("rst_req_ready", 32'(REQ_READY), 32'd0);
    modelReset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Monitor: compare every presented result with the scoreboard head, pop on acceptance
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && RES_VALID === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_nonempty", 32'(sbq.size()), 32'd1);
        end else begin
          checkOutput("res_data", 32'(RES_DATA), 32'(sbq[0].data));
          checkOutput("res_id", 32'(RES_ID), 32'(sbq[0].id));
          if (RES_READY) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting");
    doReset();

    // Single op on requester 2: 10 + 5 - 1 = 14
    applyStimulus(4'b0100, opsAt(2, 10), opsAt(2, 5), 1'b1);
    applyStimulus(4'b0000, '0, '0, 1'b1);
    applyStimulus(4'b0000, '0, '0, 1'b1);

    // Fairness: everyone requesting, zero operands
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(4'b1111, '0, '0, 1'b1);
    applyStimulus(4'b0000, '0, '0, 1'b1);

    // Backpressure: 3 + 4 - 1 = 6 held for 5 cycles, then drain-and-grant
    doReset();
    applyStimulus(4'b0001, opsAt(0, 3), opsAt(0, 4), 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, rndOps(), rndOps(), 1'b0);
    applyStimulus(4'b1111, rndOps(), rndOps(), 1'b1);
    applyStimulus(4'b0000, '0, '0, 1'b1);

    // Sequence counter wrap-around
    doReset();
    for (int i = 0; i < 255; i++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, (1 << N) - 1));
      applyStimulus(v, rndOps(), rndOps(), 1'b1);
    end
    applyStimulus(4'b0001, '0, '0, 1'b1);
    applyStimulus(4'b0010, opsAt(1, 200), opsAt(1, 100), 1'b1);
    applyStimulus(4'b0000, '0, '0, 1'b1);

    // Randomized traffic with random backpressure
    doReset();
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(N'($urandom), rndOps(), rndOps(), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while FULL, with pointer parked past requester 1
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, '0, '0, 1'b1);
    applyStimulus(4'b0010, rndOps(), rndOps(), 1'b0);
    applyStimulus(4'b0000, '0, '0, 1'b0);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("async_res_valid", 32'(RES_VALID), 32'd0);
    checkOutput("async_seq", 32'(SEQ), 32'd0);
    checkOutput("async_req_ready", 32'(REQ_READY), 32'd0);
    checkOutput("async_res_data", 32'(RES_DATA), 32'd0);
    modelReset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    applyStimulus(4'b1010, rndOps(), rndOps(), 1'b1);
    applyStimulus(4'b0000, '0, '0, 1'b1);

`ifdef ADDSUB_RR_SCHED_STATS_EN
    // Counters: 3 grants then 7 stalled cycles
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, rndOps(), rndOps(), 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(4'b0000, '0, '0, 1'b0);
    @(posedge CLK);
    #2;
    checkOutput("grant_cnt_3", 32'(GRANT_CNT), 32'd3);
    checkOutput("stall_cnt_7", 32'(STALL_CNT), 32'd7);
    applyStimulus(4'b0000, '0, '0, 1'b1);
`endif

    // Drain everything and confirm nothing was left unobserved
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, '0, '0, 1'b1);
    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
